// File: rtl/maria_bus_arbiter.sv
// ---------------------------------------------------------------------------
// maria_bus_arbiter
//
// CPU-side responder to Maria's DMA bus-request handshake. Maria asks for the
// bus by pulling halt_b low. Ownership is handed over only at the end of a
// CPU read cycle, because the 6502 cannot stall a write. While Maria owns the
// bus, the CPU clock enable is held off and the bus address comes from Maria.
// A watchdog force-releases a grant that lasts too long.
//
// Ports
//   sysclk          system clock; all state changes on the rising edge
//   reset           synchronous, active-high reset
//   cpu_phase       one-sysclk strobe marking the end of a CPU bus cycle
//   cpu_rw          CPU R/W for the current cycle (1 = read)
//   cpu_AB[15:0]    CPU address
//   halt_b          Maria DMA request, active low
//   ready           Maria ready (0 = WSYNC stall)
//   maria_drive_AB  Maria is actively driving maria_AB
//   maria_AB[15:0]  Maria DMA address
//   bus_AB[15:0]    address presented to the memory map
//   bus_we          write strobe to the memory map (CPU writes only)
//   cpu_ce          CPU clock enable
//   maria_owns      bus granted to Maria
//   wd_trip         sticky watchdog flag, cleared only by reset
//   halt_count      saturating count of sysclk cycles spent in GRANT
// ---------------------------------------------------------------------------
module maria_bus_arbiter #(
    parameter int WD_LIMIT    = 1023,
    parameter int TURN_CYCLES = 1
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        cpu_phase,
    input  logic        cpu_rw,
    input  logic [15:0] cpu_AB,
    input  logic        halt_b,
    input  logic        ready,
    input  logic        maria_drive_AB,
    input  logic [15:0] maria_AB,
    output logic [15:0] bus_AB,
    output logic        bus_we,
    output logic        cpu_ce,
    output logic        maria_owns,
    output logic        wd_trip,
    output logic [15:0] halt_count
);

    localparam int WD_W = $clog2(WD_LIMIT + 1);
    localparam int TC_W = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PEND  = 2'd1,
        ST_GRANT = 2'd2,
        ST_TURN  = 2'd3
    } state_t;

    state_t            state_q,      state_d;
    logic [WD_W-1:0]   wd_cnt_q,     wd_cnt_d;
    logic [TC_W-1:0]   turn_cnt_q,   turn_cnt_d;
    logic [15:0]       halt_count_q, halt_count_d;
    logic              wd_trip_q,    wd_trip_d;
    logic              lockout_q,    lockout_d;
    logic [15:0]       hold_ab_q,    hold_ab_d;
    logic              trip_now;
    logic              we_raw;

    always_comb begin
        state_d      = state_q;
        wd_cnt_d     = '0;
        turn_cnt_d   = '0;
        halt_count_d = halt_count_q;
        wd_trip_d    = wd_trip_q;
        // After a watchdog release, a request is ignored until halt_b has
        // been seen high once; any high sample clears the lockout.
        lockout_d    = lockout_q & ~halt_b;
        trip_now     = 1'b0;
        cpu_ce       = 1'b0;
        bus_AB       = cpu_AB;
        we_raw       = 1'b0;
        maria_owns   = 1'b0;

        case (state_q)
            ST_RUN: begin
                cpu_ce = cpu_phase & ready;
                we_raw = ~cpu_rw & cpu_phase;
                // A read strobe coinciding with the falling request is not
                // used; PEND waits for the next read boundary.
                if (!halt_b && !lockout_q) begin
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                cpu_ce = cpu_phase & ready;
                we_raw = ~cpu_rw & cpu_phase;
                // ready does not participate: the handover is decided on the
                // read boundary alone.
                if (halt_b) begin
                    state_d = ST_RUN;
                end else if (cpu_phase && cpu_rw) begin
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                maria_owns = 1'b1;
                bus_AB     = maria_drive_AB ? maria_AB : hold_ab_q;
                wd_cnt_d   = wd_cnt_q + WD_W'(1);
                if (halt_count_q != 16'hFFFF) begin
                    halt_count_d = halt_count_q + 16'd1;
                end
                // This cycle is the WD_LIMIT-th consecutive GRANT cycle.
                if (wd_cnt_q == WD_W'(WD_LIMIT - 1)) begin
                    trip_now  = 1'b1;
                    wd_trip_d = 1'b1;
                    lockout_d = 1'b1;
                    state_d   = ST_TURN;
                end else if (halt_b) begin
                    state_d = ST_TURN;
                end
            end
            ST_TURN: begin
                // A request arriving during turnaround is taken on the exit
                // edge straight into PEND.
                if (turn_cnt_q == TC_W'(TURN_CYCLES - 1)) begin
                    state_d = (!halt_b && !lockout_q) ? ST_PEND : ST_RUN;
                end else begin
                    turn_cnt_d = turn_cnt_q + TC_W'(1);
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        bus_we    = we_raw & ~reset;
        hold_ab_d = bus_AB;
    end

    assign wd_trip    = wd_trip_q | trip_now;
    assign halt_count = halt_count_q;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q      <= ST_RUN;
            wd_cnt_q     <= '0;
            turn_cnt_q   <= '0;
            halt_count_q <= '0;
            wd_trip_q    <= 1'b0;
            lockout_q    <= 1'b0;
            hold_ab_q    <= '0;
        end else begin
            state_q      <= state_d;
            wd_cnt_q     <= wd_cnt_d;
            turn_cnt_q   <= turn_cnt_d;
            halt_count_q <= halt_count_d;
            wd_trip_q    <= wd_trip_d;
            lockout_q    <= lockout_d;
            hold_ab_q    <= hold_ab_d;
        end
    end

endmodule

// File: tb/tb_maria_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_maria_bus_arbiter
//
// Directed bench for maria_bus_arbiter. A table of single-cycle vectors
// covers idle, write deferral, a short grant and the handshake corner cases;
// hand-written sequences cover the DMA window, watchdog, WSYNC stall and
// reset during a grant. A second instance with WD_LIMIT = 15 serves the
// watchdog sequence. Inputs change 1 ns after the rising edge and outputs
// are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_maria_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_phase;
    logic        cpu_rw;
    logic [15:0] cpu_AB;
    logic        halt_b;
    logic        ready;
    logic        maria_drive_AB;
    logic [15:0] maria_AB;

    logic [15:0] bus_AB,     bus_AB_w;
    logic        bus_we,     bus_we_w;
    logic        cpu_ce,     cpu_ce_w;
    logic        maria_owns, maria_owns_w;
    logic        wd_trip,    wd_trip_w;
    logic [15:0] halt_count, halt_count_w;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    maria_bus_arbiter dut (
        .sysclk(clk), .reset(reset), .cpu_phase(cpu_phase), .cpu_rw(cpu_rw),
        .cpu_AB(cpu_AB), .halt_b(halt_b), .ready(ready),
        .maria_drive_AB(maria_drive_AB), .maria_AB(maria_AB),
        .bus_AB(bus_AB), .bus_we(bus_we), .cpu_ce(cpu_ce),
        .maria_owns(maria_owns), .wd_trip(wd_trip), .halt_count(halt_count)
    );

    maria_bus_arbiter #(.WD_LIMIT(15), .TURN_CYCLES(1)) dut_w (
        .sysclk(clk), .reset(reset), .cpu_phase(cpu_phase), .cpu_rw(cpu_rw),
        .cpu_AB(cpu_AB), .halt_b(halt_b), .ready(ready),
        .maria_drive_AB(maria_drive_AB), .maria_AB(maria_AB),
        .bus_AB(bus_AB_w), .bus_we(bus_we_w), .cpu_ce(cpu_ce_w),
        .maria_owns(maria_owns_w), .wd_trip(wd_trip_w), .halt_count(halt_count_w)
    );

    typedef struct {
        logic        halt_b;
        logic        ready;
        logic        ph;
        logic        rw;
        logic [15:0] ab;
        logic        drv;
        logic [15:0] mab;
        logic        e_ce;
        logic [15:0] e_ab;
        logic        e_we;
        logic        e_own;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic h, input logic r, input logic ph,
                           input logic rw, input logic [15:0] ab,
                           input logic drv, input logic [15:0] mab,
                           input logic e_ce, input logic [15:0] e_ab,
                           input logic e_we, input logic e_own);
        vec_t v;
        v.halt_b = h;  v.ready = r;  v.ph = ph;  v.rw = rw;  v.ab = ab;
        v.drv = drv;   v.mab = mab;  v.e_ce = e_ce;  v.e_ab = e_ab;
        v.e_we = e_we; v.e_own = e_own;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        halt_b = 1'b1; ready = 1'b1; cpu_phase = 1'b0; cpu_rw = 1'b1;
        cpu_AB = 16'h1234; maria_drive_AB = 1'b0; maria_AB = 16'h0000;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        #1;
        do_reset();

        // ---------------- reset state ----------------
        #1;
        chk("rst_owns", {15'd0, maria_owns}, 16'd0);
        chk("rst_halt_count", halt_count, 16'd0);
        chk("rst_wd_trip", {15'd0, wd_trip}, 16'd0);
        chk("rst_bus_AB", bus_AB, 16'h1234);
        chk("rst_bus_we", {15'd0, bus_we}, 16'd0);
        chk("rst_cpu_ce", {15'd0, cpu_ce}, 16'd0);
        tick();
        $display("reset state checked");

        // ---------------- table of single-cycle vectors ----------------
        //       halt rdy ph rw  ab        drv mab       ce  e_ab      we own
        add_vec(1, 1, 1, 1, 16'h1234, 0, 16'h0000, 1, 16'h1234, 0, 0); // idle
        add_vec(1, 1, 0, 1, 16'h1234, 0, 16'h0000, 0, 16'h1234, 0, 0);
        add_vec(1, 1, 0, 1, 16'h1234, 0, 16'h0000, 0, 16'h1234, 0, 0);
        add_vec(1, 1, 0, 1, 16'h1234, 0, 16'h0000, 0, 16'h1234, 0, 0);
        add_vec(1, 1, 1, 1, 16'h1234, 0, 16'h0000, 1, 16'h1234, 0, 0);
        add_vec(0, 1, 0, 0, 16'h2000, 0, 16'h0000, 0, 16'h2000, 0, 0); // req
        add_vec(0, 1, 1, 0, 16'h2001, 0, 16'h0000, 1, 16'h2001, 1, 0); // wr 1
        add_vec(0, 1, 1, 0, 16'h2002, 0, 16'h0000, 1, 16'h2002, 1, 0); // wr 2
        add_vec(0, 1, 1, 0, 16'h2003, 0, 16'h0000, 1, 16'h2003, 1, 0); // wr 3
        add_vec(0, 1, 1, 1, 16'h2004, 0, 16'h4000, 1, 16'h2004, 0, 0); // read
        add_vec(0, 1, 0, 1, 16'h2005, 1, 16'h4000, 0, 16'h4000, 0, 1); // grant
        add_vec(0, 1, 0, 1, 16'h2006, 0, 16'h5555, 0, 16'h4000, 0, 1); // hold
        add_vec(1, 1, 0, 1, 16'h2007, 1, 16'h4001, 0, 16'h4001, 0, 1); // rel
        add_vec(1, 1, 1, 0, 16'h3000, 0, 16'h0000, 0, 16'h3000, 0, 0); // turn
        add_vec(1, 1, 1, 0, 16'h3001, 0, 16'h0000, 1, 16'h3001, 1, 0); // run
        add_vec(0, 1, 1, 1, 16'h3002, 0, 16'h0000, 1, 16'h3002, 0, 0); // req+rd
        add_vec(0, 1, 0, 1, 16'h3002, 0, 16'h0000, 0, 16'h3002, 0, 0); // pend
        add_vec(0, 0, 1, 1, 16'h3003, 0, 16'h0000, 0, 16'h3003, 0, 0); // rdy=0
        add_vec(1, 1, 0, 1, 16'h3004, 0, 16'h7777, 0, 16'h3003, 0, 1); // grant
        add_vec(0, 1, 0, 1, 16'h3005, 0, 16'h0000, 0, 16'h3005, 0, 0); // turn+req
        add_vec(1, 1, 0, 1, 16'h3006, 0, 16'h0000, 0, 16'h3006, 0, 0); // pend
        add_vec(1, 1, 1, 1, 16'h3007, 0, 16'h0000, 1, 16'h3007, 0, 0); // run
        add_vec(1, 1, 0, 1, 16'h3008, 0, 16'h0000, 0, 16'h3008, 0, 0); // run

        for (int i = 0; i < vecs.size(); i++) begin
            halt_b = vecs[i].halt_b; ready = vecs[i].ready;
            cpu_phase = vecs[i].ph; cpu_rw = vecs[i].rw; cpu_AB = vecs[i].ab;
            maria_drive_AB = vecs[i].drv; maria_AB = vecs[i].mab;
            #1;
            chk($sformatf("vec%0d_cpu_ce", i), {15'd0, cpu_ce}, {15'd0, vecs[i].e_ce});
            chk($sformatf("vec%0d_bus_AB", i), bus_AB, vecs[i].e_ab);
            chk($sformatf("vec%0d_bus_we", i), {15'd0, bus_we}, {15'd0, vecs[i].e_we});
            chk($sformatf("vec%0d_owns", i), {15'd0, maria_owns}, {15'd0, vecs[i].e_own});
            $display("vec %0d: halt_b=%b ph=%b rw=%b ab=%h -> ce=%b bus=%h we=%b owns=%b",
                     i, halt_b, cpu_phase, cpu_rw, cpu_AB, cpu_ce, bus_AB, bus_we, maria_owns);
            tick();
        end

        // ---------------- DMA window ----------------
        do_reset();
        halt_b = 1'b0; cpu_AB = 16'h1111;
        tick();                                     // RUN -> PEND
        cpu_phase = 1'b1; cpu_rw = 1'b1;
        #1;
        chk("dma_pend_owns", {15'd0, maria_owns}, 16'd0);
        tick();                                     // PEND -> GRANT
        cpu_phase = 1'b0;
        for (int i = 0; i < 20; i++) begin
            maria_drive_AB = 1'b1;
            maria_AB = 16'h4000 + 16'(i % 4);
            halt_b = (i == 19);
            #1;
            chk($sformatf("dma%0d_bus_AB", i), bus_AB, 16'h4000 + 16'(i % 4));
            chk($sformatf("dma%0d_owns", i), {15'd0, maria_owns}, 16'd1);
            chk($sformatf("dma%0d_cpu_ce", i), {15'd0, cpu_ce}, 16'd0);
            tick();
        end
        halt_b = 1'b1; cpu_phase = 1'b1; maria_drive_AB = 1'b0;
        #1;
        chk("dma_turn_cpu_ce", {15'd0, cpu_ce}, 16'd0);
        chk("dma_turn_owns", {15'd0, maria_owns}, 16'd0);
        chk("dma_halt_count", halt_count, 16'd20);
        chk("dma_turn_bus_AB", bus_AB, 16'h1111);
        tick();
        #1;
        chk("dma_resume_cpu_ce", {15'd0, cpu_ce}, 16'd1);
        $display("dma window: halt_count=%0d resume ce=%b", halt_count, cpu_ce);
        tick();

        // ---------------- watchdog (WD_LIMIT = 15 instance) ----------------
        do_reset();
        halt_b = 1'b0;
        tick();                                     // RUN -> PEND
        cpu_phase = 1'b1; cpu_rw = 1'b1;
        tick();                                     // PEND -> GRANT
        cpu_phase = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            #1;
            chk($sformatf("wd_grant%0d_owns", k), {15'd0, maria_owns_w}, 16'd1);
            chk($sformatf("wd_grant%0d_trip", k), {15'd0, wd_trip_w}, {15'd0, k == 15});
            chk($sformatf("wd_grant%0d_ce", k), {15'd0, cpu_ce_w}, 16'd0);
            tick();
        end
        #1;
        chk("wd_turn_owns", {15'd0, maria_owns_w}, 16'd0);
        chk("wd_turn_trip", {15'd0, wd_trip_w}, 16'd1);
        tick();
        for (int c = 0; c < 80; c++) begin
            cpu_phase = (c % 4 == 0);
            cpu_rw = 1'b1;
            #1;
            chk($sformatf("wd_lock%0d_owns", c), {15'd0, maria_owns_w}, 16'd0);
            chk($sformatf("wd_lock%0d_bus", c), bus_AB_w, 16'h1234);
            chk($sformatf("wd_lock%0d_we", c), {15'd0, bus_we_w}, 16'd0);
            tick();
        end
        $display("watchdog: trip=%b count=%0d, held off 80 cycles", wd_trip_w, halt_count_w);
        cpu_phase = 1'b0;
        halt_b = 1'b1;
        tick();
        halt_b = 1'b0;
        tick();                                     // RUN -> PEND
        cpu_phase = 1'b1;
        tick();                                     // PEND -> GRANT
        cpu_phase = 1'b0;
        #1;
        chk("wd_regrant_owns", {15'd0, maria_owns_w}, 16'd1);
        chk("wd_regrant_count", halt_count_w, 16'd15);
        chk("wd_sticky_trip", {15'd0, wd_trip_w}, 16'd1);
        $display("watchdog: re-grant after toggle owns=%b", maria_owns_w);
        tick();
        do_reset();
        #1;
        chk("wd_reset_trip", {15'd0, wd_trip_w}, 16'd0);
        tick();

        // ---------------- WSYNC stall ----------------
        do_reset();
        ready = 1'b0; cpu_AB = 16'h5678;
        for (int c = 0; c < 50; c++) begin
            cpu_phase = (c % 4 == 0);
            #1;
            chk($sformatf("wsync%0d_ce", c), {15'd0, cpu_ce}, 16'd0);
            chk($sformatf("wsync%0d_bus", c), bus_AB, 16'h5678);
            chk($sformatf("wsync%0d_owns", c), {15'd0, maria_owns}, 16'd0);
            tick();
        end
        ready = 1'b1; cpu_phase = 1'b0;
        #1;
        chk("wsync_release_ce0", {15'd0, cpu_ce}, 16'd0);
        tick();
        cpu_phase = 1'b1;
        #1;
        chk("wsync_resume_ce", {15'd0, cpu_ce}, 16'd1);
        $display("wsync: resume ce=%b", cpu_ce);
        tick();

        // ---------------- reset during GRANT ----------------
        do_reset();
        halt_b = 1'b0;
        tick();                                     // RUN -> PEND
        cpu_phase = 1'b1; cpu_rw = 1'b1;
        tick();                                     // PEND -> GRANT
        cpu_phase = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("rg%0d_owns", c), {15'd0, maria_owns}, 16'd1);
            tick();
        end
        reset = 1'b1; cpu_phase = 1'b1; cpu_rw = 1'b0; cpu_AB = 16'h9ABC;
        #1;
        chk("rg_reset_we", {15'd0, bus_we}, 16'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("rg_owns", {15'd0, maria_owns}, 16'd0);
        chk("rg_halt_count", halt_count, 16'd0);
        chk("rg_wd_trip", {15'd0, wd_trip}, 16'd0);
        chk("rg_bus_AB", bus_AB, 16'h9ABC);
        chk("rg_cpu_ce", {15'd0, cpu_ce}, 16'd1);
        $display("reset mid-grant: owns=%b count=%0d ce=%b", maria_owns, halt_count, cpu_ce);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
